// File: rtl/tick_prescaler_pkg.sv
// tick_prescaler shared types: FSM state encoding and reset divide ratio.
// Imported by the interface, shadow register and top module.
package tick_prescaler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } prescaler_state_t;

  localparam int unsigned DIV_INIT_DEF = 9;

endpackage

// File: rtl/tick_prescaler_if.sv
// Divide-ratio load port: valid/ready handshake carrying a new ratio.
// The master offers a ratio; the prescaler (slave) accepts it.
interface tick_prescaler_if #(
  parameter int W = 8
);

  logic         div_valid;
  logic [W-1:0] div_data;
  logic         div_ready;

  modport master (
    output div_valid,
    output div_data,
    input  div_ready
  );

  modport slave (
    input  div_valid,
    input  div_data,
    output div_ready
  );

endinterface

// File: rtl/tick_prescaler_shadow.sv
// One-entry holding register for a pending divide ratio.
// Accepts while empty; the owner drains it with take_i.
module tick_prescaler_shadow
  import tick_prescaler_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  input  logic         take_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // take_i only fires while full and accepts only while empty,
  // so the two never collide on one edge
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (take_i) begin
      full_d = 1'b0;
    end
    if (valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign ready_o = !full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule

// File: rtl/tick_prescaler.sv
// Programmable tick generator: one-cycle tick every div_act+1 clocks.
// TICK_PRESCALER_SHADOW_EN defers ratio loads to the next tick boundary.
module tick_prescaler
  import tick_prescaler_pkg::*;
#(
  parameter int W        = 8,
  parameter int DIV_INIT = DIV_INIT_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  hold,
  input  logic                  oneshot,
  tick_prescaler_if.slave       div_if,
  output logic                  tick,
  output logic                  busy,
  output logic [W-1:0]          phase
);

  prescaler_state_t state_q, state_d;
  logic [W-1:0]     phase_q, phase_d;
  logic [W-1:0]     div_act_q, div_act_d;
  logic             tick_q, tick_d;
  logic             os_q, os_d;

  logic             active;
  logic             boundary;
  logic             load;
  logic             imm_load;
  logic [W-1:0]     load_val;

  assign active   = (state_q != IDLE);
  assign boundary = active && !stop && !hold && !imm_load
                    && (phase_q == div_act_q);

`ifdef TICK_PRESCALER_SHADOW_EN
  logic         sh_full;
  logic [W-1:0] sh_data;
  logic         sh_take;

  assign sh_take  = sh_full && (boundary || state_q == IDLE);
  assign load     = sh_take;
  assign imm_load = 1'b0;
  assign load_val = sh_data;

  tick_prescaler_shadow #(
    .W (W)
  ) u_shadow (
    .clock   (clock),
    .reset_n (reset_n),
    .valid_i (div_if.div_valid),
    .data_i  (div_if.div_data),
    .ready_o (div_if.div_ready),
    .take_i  (sh_take),
    .full_o  (sh_full),
    .data_o  (sh_data)
  );
`else
  assign div_if.div_ready = 1'b1;
  assign load     = div_if.div_valid;
  assign imm_load = div_if.div_valid;
  assign load_val = div_if.div_data;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    tick_d    = 1'b0;
    os_d      = os_q;
    div_act_d = load ? load_val : div_act_q;

    if (stop) begin
      state_d = IDLE;
      phase_d = '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        phase_d = '0;
        os_d    = oneshot;
      end
    end else if (hold) begin
      state_d = HOLD;
      if (imm_load) begin
        phase_d = '0;
      end
    end else begin
      // leaving HOLD counts as a normal RUN edge, so each
      // held cycle stretches the period by exactly one
      state_d = RUN;
      if (imm_load) begin
        phase_d = '0;
      end else if (boundary) begin
        phase_d = '0;
        tick_d  = 1'b1;
        if (os_q) begin
          state_d = IDLE;
        end
      end else begin
        phase_d = phase_q + W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      div_act_q <= W'(DIV_INIT);
      tick_q    <= 1'b0;
      os_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      div_act_q <= div_act_d;
      tick_q    <= tick_d;
      os_q      <= os_d;
    end
  end

  assign tick  = tick_q;
  assign busy  = active;
  assign phase = phase_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Self-checking bench for tick_prescaler: expected tick edges are
// queued when stimulus is driven and matched against observed ticks.
module tb_tick_prescaler;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic       stop    = 1'b0;
  logic       hold    = 1'b0;
  logic       oneshot = 1'b0;
  logic       tick;
  logic       busy;
  logic [7:0] phase;

  tick_prescaler_if #(.W(8)) bus ();

  tick_prescaler #(
    .W        (8),
    .DIV_INIT (9)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .hold    (hold),
    .oneshot (oneshot),
    .div_if  (bus),
    .tick    (tick),
    .busy    (busy),
    .phase   (phase)
  );

  always #5 clock = ~clock;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int obs_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  // tick seen at a falling edge is tagged with the rising edge that set it
  always @(negedge clock) if (tick === 1'b1) obs_q.push_back(cyc);

  task automatic load_div(input logic [7:0] v);
    bus.div_valid = 1'b1;
    bus.div_data  = v;
    @(negedge clock);
    bus.div_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_start(input logic os, output int s);
    start   = 1'b1;
    oneshot = os;
    s       = cyc + 1;
    @(negedge clock);
    start   = 1'b0;
    oneshot = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++;
    if (tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick got %b expected 0", tick);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b expected 0", busy);
    end
    checks++;
    if (phase !== 8'd0) begin
      errors++; $display("FAIL reset_phase got %0d expected 0", phase);
    end
    checks++;
    if (bus.div_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b expected 1", bus.div_ready);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_run_default();
    int s, e, o;
    obs_q.delete();
    do_start(1'b0, s);
    for (int k = 1; k <= 3; k++) exp_q.push_back(s + 10 * k);
    while (cyc < s + 32) begin
      if (cyc == s) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL run_busy got %b expected 1", busy);
        end
      end
      if (cyc == s + 9) begin
        checks++;
        if (phase !== 8'd9) begin
          errors++; $display("FAIL run_phase9 got %0d expected 9", phase);
        end
      end
      if (cyc == s + 10) begin
        checks++;
        if (phase !== 8'd0) begin
          errors++; $display("FAIL run_wrap got %0d expected 0", phase);
        end
      end
      @(negedge clock);
    end
    do_stop();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL run_ticks count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL run_ticks edge got %0d expected %0d", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_oneshot();
    int s, e, o;
    load_div(8'd3);
    obs_q.delete();
    do_start(1'b1, s);
    exp_q.push_back(s + 4);
    while (cyc < s + 15) begin
      if (cyc == s + 3) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL oneshot_busy_hi got %b expected 1", busy);
        end
      end
      if (cyc == s + 4) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL oneshot_busy_fall got %b expected 0", busy);
        end
      end
      @(negedge clock);
    end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL oneshot_ticks count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL oneshot_ticks edge got %0d expected %0d", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_hold();
    int s, e, o;
    load_div(8'd4);
    obs_q.delete();
    do_start(1'b0, s);
    // 3 held edges stretch the second period from 5 to 8
    exp_q.push_back(s + 5);
    exp_q.push_back(s + 13);
    exp_q.push_back(s + 18);
    exp_q.push_back(s + 23);
    while (cyc < s + 25) begin
      hold = (cyc >= s + 6) && (cyc <= s + 8);
      if (cyc >= s + 7 && cyc <= s + 9) begin
        checks++;
        if (phase !== 8'd1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL hold_phase got %0d/%b expected 1/1", phase, busy);
        end
      end
      @(negedge clock);
    end
    hold = 1'b0;
    do_stop();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL hold_ticks count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL hold_ticks edge got %0d expected %0d", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_stop();
    int s;
    load_div(8'd4);
    obs_q.delete();
    do_start(1'b0, s);
    while (cyc < s + 5) begin
      stop = (cyc == s + 4);
      @(negedge clock);
    end
    stop = 1'b0;
    checks++;
    if (tick !== 1'b0 || busy !== 1'b0 || phase !== 8'd0) begin
      errors++;
      $display("FAIL stop_due got %b/%b/%0d expected 0/0/0", tick, busy, phase);
    end
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || phase !== 8'd0) begin
      errors++;
      $display("FAIL start_stop got %b/%0d expected 0/0", busy, phase);
    end
    repeat (6) @(negedge clock);
    checks++;
    if (obs_q.size() !== 0) begin
      errors++; $display("FAIL stop_ticks count got %0d expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_load_run();
    int s, e, o, fin;
    load_div(8'd7);
    obs_q.delete();
    do_start(1'b0, s);
`ifdef TICK_PRESCALER_SHADOW_EN
    fin = s + 13;
    for (int t = s + 8; t <= fin; t += 2) exp_q.push_back(t);
    while (cyc < fin) begin
      bus.div_valid = (cyc >= s + 2) && (cyc <= s + 6);
      bus.div_data  = 8'd1;
      if (cyc >= s + 3 && cyc <= s + 7) begin
        checks++;
        if (bus.div_ready !== 1'b0) begin
          errors++; $display("FAIL shadow_ready_lo got %b expected 0", bus.div_ready);
        end
      end
      if (cyc == s + 8) begin
        checks++;
        if (bus.div_ready !== 1'b1) begin
          errors++; $display("FAIL shadow_ready_hi got %b expected 1", bus.div_ready);
        end
      end
      @(negedge clock);
    end
`else
    fin = s + 14;
    for (int t = s + 5; t <= fin; t += 2) exp_q.push_back(t);
    while (cyc < fin) begin
      bus.div_valid = (cyc == s + 2);
      bus.div_data  = 8'd1;
      if (cyc == s + 3) begin
        checks++;
        if (phase !== 8'd0 || bus.div_ready !== 1'b1) begin
          errors++;
          $display("FAIL imm_load got %0d/%b expected 0/1", phase, bus.div_ready);
        end
      end
      @(negedge clock);
    end
`endif
    bus.div_valid = 1'b0;
    do_stop();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL load_ticks count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL load_ticks edge got %0d expected %0d", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int s, e, o;
    load_div(8'd200);
    obs_q.delete();
    do_start(1'b0, s);
    while (cyc < s + 6) begin
      bus.div_valid = (cyc == s + 3);
      bus.div_data  = 8'd3;
      reset_n       = !(cyc == s + 5);
`ifdef TICK_PRESCALER_SHADOW_EN
      if (cyc == s + 4) begin
        checks++;
        if (bus.div_ready !== 1'b0) begin
          errors++; $display("FAIL mid_full got %b expected 0", bus.div_ready);
        end
      end
`endif
      @(negedge clock);
    end
    reset_n = 1'b1;
    checks++;
    if (tick !== 1'b0 || busy !== 1'b0 || phase !== 8'd0 || bus.div_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got %b/%b/%0d/%b expected 0/0/0/1",
               tick, busy, phase, bus.div_ready);
    end
    do_start(1'b0, s);
    exp_q.push_back(s + 10);
    while (cyc < s + 12) @(negedge clock);
    do_stop();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL mid_ticks count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL mid_ticks edge got %0d expected %0d", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_div_zero();
    int s, e, o;
    load_div(8'd0);
    obs_q.delete();
    do_start(1'b0, s);
    for (int t = s + 1; t <= s + 6; t++) exp_q.push_back(t);
    while (cyc < s + 6) @(negedge clock);
    do_stop();
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL zero_ticks count got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        errors++; $display("FAIL zero_ticks edge got %0d expected %0d", o, e);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    bus.div_valid = 1'b0;
    bus.div_data  = 8'd0;
    test_reset();
    test_run_default();
    test_oneshot();
    test_hold();
    test_stop();
    test_load_run();
    test_reset_mid();
    test_div_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_prescaler.md
# tick_prescaler

Programmable clock-enable generator that sits directly upstream of the team's up-counters. Emits a one-cycle `tick` every `div+1` clocks, which drives a counter's count-enable so the counter advances at a reduced, software-selected rate. Supports run/hold/stop control, one-shot mode, and a valid/ready port for loading a new divide ratio.

## Interface
- `W`, default 8: width of divide ratio and phase counter.
- `DIV_INIT`, default 9: divide ratio loaded at reset (period = `DIV_INIT+1` clocks).
- `clock` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `start` in 1: level sampled each edge; starts counting from IDLE.
- `stop` in 1: returns to IDLE from any state.
- `hold` in 1: freezes phase while high (RUN↔HOLD).
- `oneshot` in 1: mode, sampled on the edge that accepts `start`.
- `div_valid` in 1: new divide ratio offered.
- `div_data` in W: new divide ratio; period = `div_data+1`.
- `div_ready` out 1: ratio slot can accept.
- `tick` out 1: registered one-cycle enable pulse.
- `busy` out 1: high in RUN or HOLD.
- `phase` out W: current phase count.

## Operation
- States: IDLE, RUN, HOLD. Internal `div_act` (active ratio) and `os_mode` flag.
- IDLE: phase=0, tick=0. `start`=1 and `stop`=0 → RUN, phase←0, `os_mode`←`oneshot`.
- RUN: if phase==`div_act`, then phase←0 and tick←1, otherwise phase←phase+1 and tick←0. If `os_mode`, the tick edge also → IDLE.
- RUN with `hold`=1 → HOLD (the phase update and tick generation for that edge are suppressed). HOLD with `hold`=0 → RUN; phase is kept.
- `stop`=1 in any state → IDLE, phase←0, tick←0. Priority: `reset_n` > `stop` > `hold` > tick boundary > `start`.
- `start` in RUN/HOLD is ignored (no restart).
- `div_act`=0: tick on every RUN cycle (tick stays high continuously).
- Phase arithmetic: unsigned W-bit. Phase never exceeds `div_act` except transiently on an immediate load (see Configuration).
- Handshake: a transfer occurs on an edge where `div_valid`=1 and `div_ready`=1. `div_data` must be stable while `div_valid` is high and not yet accepted.
- Reset: state=IDLE, tick=0, busy=0, phase=0, `div_act`=`DIV_INIT`, `div_ready`=1, shadow empty, `os_mode`=0. The same values apply when reset is asserted mid-operation.

## Timing
- If `start` is sampled at edge 0, the first tick is high during the cycle after edge `div_act+1`. Subsequent ticks repeat every `div_act+1` cycles.
- Example, `div_act`=3: phase 0,1,2,3,0…; tick high for 1 cycle in every 4.
- `busy` rises on the edge after `start` is sampled. In one-shot mode, `busy` falls on the same edge at which tick rises.
- Each cycle spent in HOLD extends the current period by exactly one cycle.
- `stop` takes effect on the next edge. A tick due at that edge is not emitted.

## Configuration
- Macro `TICK_PRESCALER_SHADOW_EN`.
- Defined:
  - A one-entry shadow register holds an accepted ratio.
  - `div_ready`=0 while the shadow is full.
  - The shadow is copied to `div_act` at the next tick edge, or on the next edge if in IDLE. The shadow then empties and `div_ready` returns to 1 on the same edge.
  - The current period is never truncated.
- Undefined:
  - `div_ready` is tied to 1.
  - An accepted ratio loads `div_act` immediately and sets phase←0 on the same edge. No tick is emitted on that edge.
  - If the accept and a tick boundary fall on the same edge, the load wins.

## Structure
- `tick_prescaler_pkg`: state enum `prescaler_state_t` (IDLE, RUN, HOLD) and the `DIV_INIT` default constant.
- Sub-module `tick_prescaler_shadow`: ratio holding register with valid/ready logic. It is instantiated only under `TICK_PRESCALER_SHADOW_EN`.
- The FSM and phase counter live in the top module.

## Test plan
- Reset, then `start` with `DIV_INIT`=9 → first tick 10 cycles after start, then every 10 cycles; `phase` wraps 9→0.
- `oneshot`=1, `div_data`=3 loaded in IDLE, `start` → exactly one tick 4 cycles after start, `busy` falls with it, no further ticks.
- `div_act`=4, `hold` high for 3 cycles mid-period → that period is 8 cycles, `phase` constant during hold, later periods are 5 cycles.
- `stop` and a due tick on the same edge → no tick, IDLE, phase=0. `start` and `stop` asserted together in IDLE → stays IDLE.
- With shadow: load 1 during a period of 7 → current period completes at 8 cycles; a second `div_valid` sees `div_ready`=0 until that tick; next period is 2 cycles. Without shadow: load 1 → phase=0 next edge, tick 2 cycles later.
- `reset_n` low for 1 cycle mid-RUN with the shadow full → all outputs at reset values, `div_act`=9, `div_ready`=1. `div_act`=0 → `tick` continuously high while RUN.
